// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the async FIFO.
// Synchronizes the Gray write pointer, advances the read pointer and derives occupancy flags.
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wptr_gray_async,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              rd_valid
);

    localparam int unsigned PW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (AE_LEVEL >= DEPTH) begin : g_bad_ae_level
        $error("fifo_rd_ctrl: AE_LEVEL must be below the FIFO depth");
    end

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] occ_next;
    logic          acc;

    // Two-flop synchronizer for the write pointer; only wq2 is consumed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wptr_gray_async;
            wq2 <= wq1;
        end
    end

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(wq2 >> i);
        end
    end

    always_comb begin
        acc        = rd_en & ~empty;
        rbin_next  = rbin + PW'(acc);
        rgray_next = rbin_next ^ (rbin_next >> 1);
        occ_next   = wbin - rbin_next;
    end

    // Pointer and flag registers; flags see this cycle's read immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            rd_valid     <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wq2);
            almost_empty <= (occ_next <= PW'(AE_LEVEL));
            rd_count     <= occ_next;
            rd_valid     <= acc;
        end
    end

    assign raddr = rbin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: directed stimulus queues hand-computed expectations,
// a monitor compares them against the DUT one edge at a time.
module tb_fifo_rd_ctrl;

    typedef struct packed {
        logic [3:0] raddr;
        logic [4:0] gray;
        logic       empty;
        logic       ae;
        logic [4:0] cnt;
        logic       valid;
    } obs_t;

    localparam logic [4:0] GRAY_LUT [0:31] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100,
        5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000,
        5'b11000, 5'b11001, 5'b11011, 5'b11010, 5'b11110, 5'b11111, 5'b11101, 5'b11100,
        5'b10100, 5'b10101, 5'b10111, 5'b10110, 5'b10010, 5'b10011, 5'b10001, 5'b10000
    };

    logic       clk;
    logic       nrst;
    logic       rd_en;
    logic [4:0] wptr;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    fifo_rd_ctrl #(.ADDR_W(4), .AE_LEVEL(2)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .rd_en           (rd_en),
        .wptr_gray_async (wptr),
        .raddr           (raddr),
        .rptr_gray       (rptr_gray),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .rd_count        (rd_count),
        .rd_valid        (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [4:0] rb, input logic [4:0] occ, input logic v);
        obs_t e;
        e.raddr = rb[3:0];
        e.gray  = GRAY_LUT[rb];
        e.empty = (occ == 5'd0);
        e.ae    = (occ <= 5'd2);
        e.cnt   = occ;
        e.valid = v;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {raddr, rptr_gray, empty, almost_empty, rd_count, rd_valid};
        return o;
    endfunction

    task automatic compare(input string tag, input obs_t act, input obs_t e);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got raddr=%0d gray=%b empty=%b ae=%b cnt=%0d valid=%b, want raddr=%0d gray=%b empty=%b ae=%b cnt=%0d valid=%b",
                     tag, act.raddr, act.gray, act.empty, act.ae, act.cnt, act.valid,
                     e.raddr, e.gray, e.empty, e.ae, e.cnt, e.valid);
        end
    endtask

    // One stimulus cycle: drive inputs on the falling edge and queue the post-edge expectation.
    task automatic cyc(input logic n, input logic rd, input logic [4:0] wg,
                       input obs_t e, input string tag);
        @(negedge clk);
        nrst  = n;
        rd_en = rd;
        wptr  = wg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: compares each rising edge against the scoreboard and tracks one-bit Gray steps.
    initial begin
        logic [4:0] prev_gray;
        logic       prev_ok;
        obs_t       act;
        obs_t       e;
        string      tag;
        prev_ok   = 1'b0;
        prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            act = observe();
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                compare(tag, act, e);
            end
            if (nrst && prev_ok) begin
                n_checks++;
                if ($countones(prev_gray ^ rptr_gray) > 1) begin
                    n_fail++;
                    $display("FAIL gray_step: got %b -> %b, want at most one bit change",
                             prev_gray, rptr_gray);
                end
            end
            prev_ok   = nrst;
            prev_gray = rptr_gray;
        end
    end

    initial begin
        nrst  = 1'b0;
        rd_en = 1'b0;
        wptr  = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'($urandom), 5'($urandom), mk(5'd0, 5'd0, 1'b0), "reset_hold");
        // Reads while empty are ignored.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, GRAY_LUT[0], mk(5'd0, 5'd0, 1'b0), "idle_empty");

        // Sync latency: one entry appears after the third edge.
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd0, 5'd0, 1'b0), "sync_e1");
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd0, 5'd0, 1'b0), "sync_e2");
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd0, 5'd1, 1'b0), "sync_e3");

        // Last-entry read, then a second request that must be ignored.
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd1, 5'd0, 1'b1), "last_read");
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd1, 5'd0, 1'b0), "read_on_empty");
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd1, 5'd0, 1'b0), "after_last");

        // Fresh reset, then a full FIFO (write pointer binary 16).
        cyc(1'b0, 1'b0, GRAY_LUT[16], mk(5'd0, 5'd0, 1'b0), "reset2");
        cyc(1'b0, 1'b0, GRAY_LUT[16], mk(5'd0, 5'd0, 1'b0), "reset2");
        cyc(1'b1, 1'b0, GRAY_LUT[16], mk(5'd0, 5'd0, 1'b0), "full_sync1");
        cyc(1'b1, 1'b0, GRAY_LUT[16], mk(5'd0, 5'd0, 1'b0), "full_sync2");
        cyc(1'b1, 1'b0, GRAY_LUT[16], mk(5'd0, 5'd16, 1'b0), "full_sync3");
        for (int j = 1; j <= 16; j++)
            cyc(1'b1, 1'b1, GRAY_LUT[16], mk(5'(j), 5'(16 - j), 1'b1), "drain");
        cyc(1'b1, 1'b1, GRAY_LUT[16], mk(5'd16, 5'd0, 1'b0), "drain_empty");

        // Preload the read pointer to 30.
        cyc(1'b1, 1'b0, GRAY_LUT[30], mk(5'd16, 5'd0, 1'b0), "pre_sync1");
        cyc(1'b1, 1'b0, GRAY_LUT[30], mk(5'd16, 5'd0, 1'b0), "pre_sync2");
        cyc(1'b1, 1'b0, GRAY_LUT[30], mk(5'd16, 5'd14, 1'b0), "pre_sync3");
        for (int j = 1; j <= 14; j++)
            cyc(1'b1, 1'b1, GRAY_LUT[30], mk(5'(16 + j), 5'(14 - j), 1'b1), "preload");

        // Write pointer laps to binary 1: three entries across the pointer wrap.
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd30, 5'd0, 1'b0), "wrap_sync1");
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd30, 5'd0, 1'b0), "wrap_sync2");
        cyc(1'b1, 1'b0, GRAY_LUT[1], mk(5'd30, 5'd3, 1'b0), "wrap_sync3");
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd31, 5'd2, 1'b1), "wrap_rd31");
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd0, 5'd1, 1'b1), "wrap_rd0");
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd1, 5'd0, 1'b1), "wrap_rd1");
        cyc(1'b1, 1'b1, GRAY_LUT[1], mk(5'd1, 5'd0, 1'b0), "wrap_empty");

        // Read and write-pointer advance in the same cycles.
        cyc(1'b1, 1'b0, GRAY_LUT[3], mk(5'd1, 5'd0, 1'b0), "simul_sync1");
        cyc(1'b1, 1'b0, GRAY_LUT[3], mk(5'd1, 5'd0, 1'b0), "simul_sync2");
        cyc(1'b1, 1'b0, GRAY_LUT[3], mk(5'd1, 5'd2, 1'b0), "simul_sync3");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd2, 5'd1, 1'b1), "simul_c1");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd3, 5'd0, 1'b1), "simul_c2");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd3, 5'd3, 1'b0), "simul_c3");
        cyc(1'b1, 1'b0, GRAY_LUT[6], mk(5'd3, 5'd3, 1'b0), "simul_c4");

        // Burst interrupted by an asynchronous reset between clock edges.
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd4, 5'd2, 1'b1), "burst1");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd5, 5'd1, 1'b1), "burst2");
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        compare("async_reset", observe(), mk(5'd0, 5'd0, 1'b0));
        cyc(1'b0, 1'b1, GRAY_LUT[6], mk(5'd0, 5'd0, 1'b0), "rst_hold");
        cyc(1'b0, 1'b1, GRAY_LUT[6], mk(5'd0, 5'd0, 1'b0), "rst_hold");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd0, 5'd0, 1'b0), "resume_e1");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd0, 5'd0, 1'b0), "resume_e2");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd0, 5'd6, 1'b0), "resume_e3");
        cyc(1'b1, 1'b1, GRAY_LUT[6], mk(5'd1, 5'd5, 1'b1), "resume_rd");
        cyc(1'b1, 1'b0, GRAY_LUT[6], mk(5'd1, 5'd5, 1'b0), "resume_idle");

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side pointer and flag controller for the async FIFO. It runs entirely in the read clock domain and brings the Gray-coded write pointer across through a two-flop synchronizer. It advances the read pointer on accepted reads and generates the binary RAM read address. It also returns a registered Gray read pointer to the write domain and produces empty, almost-empty, occupancy and read-valid indications.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL. Legal range 0..2^ADDR_W-1.

Ports:
- clk  in  1  read-domain clock.
- nrst  in  1  reset, asynchronous, active-low.
- rd_en  in  1  read request from consumer.
- wptr_gray_async  in  ADDR_W+1  Gray write pointer from the write domain; asynchronous to clk.
- raddr  out  ADDR_W  binary read address to the synchronous-read RAM.
- rptr_gray  out  ADDR_W+1  registered Gray read pointer to the write-domain synchronizer.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered occupancy <= AE_LEVEL.
- rd_count  out  ADDR_W+1  registered occupancy as seen by the read domain, range 0..2^ADDR_W.
- rd_valid  out  1  RAM read data valid; high the cycle after an accepted read.

## Operation
- Synchronizer: wq1 <= wptr_gray_async; wq2 <= wq1. Both flops reset to 0. Only wq2 is used downstream.
- wbin = Gray-to-binary(wq2), computed combinationally (XOR prefix from MSB).
- Accept: acc = rd_en & ~empty. A read while empty is ignored: no pointer change, rd_valid stays 0.
- Pointer update:
  - rbin_next = rbin + acc, mod 2^(ADDR_W+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - Register rbin <= rbin_next and rptr_gray <= rgray_next.
  - rptr_gray changes by exactly one bit per accepted read.
- raddr = rbin[ADDR_W-1:0], driven from the register with no combinational path from rd_en.
- Flags:
  - empty <= (rgray_next == wq2).
  - rd_count <= wbin - rbin_next, mod 2^(ADDR_W+1).
  - almost_empty <= ((wbin - rbin_next) <= AE_LEVEL).
- rd_valid <= acc.
- Wrap-around:
  - rbin rolls over from 2^(ADDR_W+1)-1 to 0.
  - raddr rolls over from 2^ADDR_W-1 to 0.
  - The MSB distinguishes laps, so full occupancy reads as rd_count = 2^ADDR_W, not 0.
- Flags are pessimistic. empty asserts on the same edge that consumes the last entry. It deasserts only after the synchronizer delay.
- Reset, including mid-operation: all registers return asynchronously to their reset values. Any in-flight rd_valid is dropped.

## Timing
- Reset values:
  - wq1, wq2, rbin: 0.
  - raddr, rptr_gray, rd_count: 0.
  - empty, almost_empty: 1.
  - rd_valid: 0.
- Write-pointer latency: a change on wptr_gray_async, stable before edge N, is reflected in empty, rd_count and almost_empty after edge N+2, i.e. the third rising edge.
- Read latency:
  - An accepted read at edge N updates raddr, rptr_gray, rd_count and flags at edge N.
  - rd_valid is high for the cycle following edge N.
  - RAM data addressed before edge N is valid while rd_valid = 1.
- Back-to-back reads: one accept per cycle is sustained while empty = 0.
- Simultaneous read and write-pointer advance: rd_count is the net result of both (wbin − rbin_next), with no lost updates.

## Test plan
- Reset: hold nrst low with random inputs → empty=1, almost_empty=1, raddr=0, rptr_gray=0, rd_count=0, rd_valid=0. Outputs stay there until the first valid write pointer.
- Sync latency (ADDR_W=4): wptr_gray_async 00000→00001 before edge 1 → empty=1 after edges 1 and 2. After edge 3: empty=0, rd_count=1, almost_empty=1.
- Last-entry read (1 entry): rd_en high for 2 cycles →
  - First edge: raddr 0→1, rptr_gray=00001, empty=1, rd_count=0.
  - Second request ignored: raddr stays 1.
  - rd_valid high for exactly one cycle.
- Full drain: wptr_gray_async=11000 (binary 16) → after sync, rd_count=16, almost_empty=0. 16 continuous reads →
  - raddr steps 0..15 then wraps to 0.
  - almost_empty=1 once rd_count<=2.
  - empty=1 on the 16th accept edge, with rptr_gray=11000.
- Pointer wrap: preload to rbin=30 via reads and supply wptr binary 1 (gray 00001, lap wrapped) → rd_count=3. Three reads →
  - rptr_gray sequence 10001→10000→00000→00001.
  - Each step changes exactly one bit.
  - empty=1 at the end.
- Reset mid-burst: assert nrst during a continuous read burst with rd_valid=1 → all outputs return to reset values immediately, without waiting for a clock edge. After release, reads resume only after the 3-edge sync latency.
